ps2_hex_entry: RTL and testbench

PS2_HEX_ENTRY -- requirements
Module: ps2_hex_entry

---
 rtl/ps2_pkg.sv | 66 ++++++
 rtl/ps2_rx.sv | 118 +++++++++++
 rtl/ps2_hex_entry.sv | 72 +++++++
 tb/tb_ps2_hex_entry.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scan codes, receiver states and hex-key decode for the PS/2 hex entry block
package ps2_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 50000;

  localparam logic [7:0] SC_EXTENDED  = 8'hE0;
  localparam logic [7:0] SC_BREAK     = 8'hF0;
  localparam logic [7:0] SC_ENTER     = 8'h5A;
  localparam logic [7:0] SC_BACKSPACE = 8'h66;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] nibble;
  } hex_key_t;

  function automatic hex_key_t hex_decode(input logic [7:0] code);
    hex_key_t k;
    k.hit    = 1'b1;
    k.nibble = 4'h0;
    case (code)
      SC_0:    k.nibble = 4'h0;
      SC_1:    k.nibble = 4'h1;
      SC_2:    k.nibble = 4'h2;
      SC_3:    k.nibble = 4'h3;
      SC_4:    k.nibble = 4'h4;
      SC_5:    k.nibble = 4'h5;
      SC_6:    k.nibble = 4'h6;
      SC_7:    k.nibble = 4'h7;
      SC_8:    k.nibble = 4'h8;
      SC_9:    k.nibble = 4'h9;
      SC_A:    k.nibble = 4'hA;
      SC_B:    k.nibble = 4'hB;
      SC_C:    k.nibble = 4'hC;
      SC_D:    k.nibble = 4'hD;
      SC_E:    k.nibble = 4'hE;
      SC_F:    k.nibble = 4'hF;
      default: k.hit    = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: synchronizers, falling-edge detect, framing FSM, inter-edge timeout
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_strobe,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  rx_state_t state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          strobe_n, err_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RX_IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      par         <= 1'b0;
      tmo         <= '0;
      byte_strobe <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      par         <= par_n;
      tmo         <= tmo_n;
      byte_strobe <= strobe_n;
      error       <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    strobe_n  = 1'b0;
    err_n     = 1'b0;
    tmo_n     = (state == RX_IDLE || fall) ? '0 : tmo + TW'(1);

    case (state)
      RX_IDLE: begin
        if (fall && !data_s2) begin
          state_n   = RX_DATA;
          bit_cnt_n = 3'd0;
          par_n     = 1'b0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shift_n   = {data_s2, shift[7:1]};
          par_n     = par ^ data_s2;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_n   = par ^ data_s2;
          state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          state_n = RX_IDLE;
          // par now covers data plus parity bit; a good frame has an odd total
          if (data_s2 && par) strobe_n = 1'b1;
          else                err_n    = 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase

    if (state != RX_IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = RX_IDLE;
      err_n   = 1'b1;
      tmo_n   = '0;
    end
  end

  assign data_byte = shift;

endmodule

// File: rtl/ps2_hex_entry.sv
// rtl/ps2_hex_entry.sv - PS/2 keyboard hex operand entry: digits, backspace and enter build a 16-bit value
module ps2_hex_entry
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [2:0]  digit_count,
  output logic        frame_error
);

  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic        rx_error;
  logic [15:0] entry;
  logic        break_pending;
  hex_key_t    key;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_byte  (rx_byte),
    .byte_strobe(rx_strobe),
    .error      (rx_error)
  );

  assign key         = hex_decode(rx_byte);
  assign frame_error = rx_error;

  always_ff @(posedge clk) begin
    if (!reset) begin
      value         <= 16'h0000;
      value_valid   <= 1'b0;
      digit_count   <= 3'd0;
      entry         <= 16'h0000;
      break_pending <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (rx_strobe) begin
        // E0 is transparent so keypad keys decode like their main-block twins
        if (rx_byte == SC_EXTENDED) begin
          break_pending <= break_pending;
        end else if (rx_byte == SC_BREAK) begin
          break_pending <= 1'b1;
        end else if (break_pending) begin
          break_pending <= 1'b0;
        end else if (key.hit) begin
          entry <= {entry[11:0], key.nibble};
          if (digit_count != 3'd4) digit_count <= digit_count + 3'd1;
        end else if (rx_byte == SC_BACKSPACE) begin
          entry <= entry >> 4;
          if (digit_count != 3'd0) digit_count <= digit_count - 3'd1;
        end else if (rx_byte == SC_ENTER && digit_count != 3'd0) begin
          value       <= entry;
          value_valid <= 1'b1;
          entry       <= 16'h0000;
          digit_count <= 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_hex_entry.sv
// tb/tb_ps2_hex_entry.sv - scoreboard bench for ps2_hex_entry
module tb_ps2_hex_entry;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] value;
  logic        value_valid;
  logic [2:0]  digit_count;
  logic        frame_error;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_val_q[$];
  int          exp_err_q[$];
  logic        prev_valid = 1'b0;
  logic        prev_err = 1'b0;
  logic        mon_en = 1'b0;

  ps2_hex_entry #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .value      (value),
    .value_valid(value_valid),
    .digit_count(digit_count),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (value_valid) begin
        check("valid_width", {31'd0, prev_valid}, 0);
        if (exp_val_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("value", {16'd0, value}, {16'd0, exp_val_q.pop_front()});
      end
      if (frame_error) begin
        check("err_width", {31'd0, prev_err}, 0);
        if (exp_err_q.size() == 0) check("unexpected_err", 1, 0);
        else void'(exp_err_q.pop_front());
      end
    end
    prev_valid = value_valid;
    prev_err   = frame_error;
  end

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (5) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (10) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (5) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par = 1'b0);
    logic par;
    par = (~^code) ^ bad_par;
    send_bits({1'b1, par, code, 1'b0}, 11);
    ps2_data = 1'b1;
    repeat (30) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check({tag, "_val_q"}, exp_val_q.size(), 0);
    check({tag, "_err_q"}, exp_err_q.size(), 0);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_value", {16'd0, value}, 0);
    check("rst_valid", {31'd0, value_valid}, 0);
    check("rst_count", {29'd0, digit_count}, 0);
    check("rst_err", {31'd0, frame_error}, 0);
    @(posedge clk);
    reset    = 1'b1;
    mon_en   = 1'b1;
    repeat (5) @(posedge clk);

    // a falling edge with data high is not a start bit
    send_bits(11'h001, 1);
    repeat (30) @(posedge clk);
    send_frame(8'h21); send_frame(8'h1C); send_frame(8'h2B); send_frame(8'h24);
    @(negedge clk);
    check("cafe_count4", {29'd0, digit_count}, 4);
    exp_val_q.push_back(16'hCAFE);
    send_frame(8'h5A);
    drain("cafe");
    check("cafe_count0", {29'd0, digit_count}, 0);

    send_frame(8'h16);
    exp_err_q.push_back(1);
    send_frame(8'h16, 1'b1);
    drain("parity");
    check("parity_count", {29'd0, digit_count}, 1);
    check("parity_value", {16'd0, value}, 16'hCAFE);

    send_frame(8'h66);
    send_frame(8'h66);
    @(negedge clk);
    check("bksp_sat", {29'd0, digit_count}, 0);
    send_frame(8'hF0); send_frame(8'h16); send_frame(8'h5A);
    drain("break");
    check("break_count", {29'd0, digit_count}, 0);
    check("break_value", {16'd0, value}, 16'hCAFE);

    send_frame(8'h16); send_frame(8'h1E); send_frame(8'h26); send_frame(8'h25); send_frame(8'h2E);
    @(negedge clk);
    check("sat_count", {29'd0, digit_count}, 4);
    exp_val_q.push_back(16'h2345);
    send_frame(8'h5A);
    drain("sat");
    send_frame(8'h16); send_frame(8'h1E); send_frame(8'h66);
    exp_val_q.push_back(16'h0001);
    send_frame(8'h5A);
    drain("bksp");

    exp_err_q.push_back(1);
    send_bits({1'b1, 1'b0, 8'h45, 1'b0}, 5);
    repeat (TMO + 20) @(posedge clk);
    ps2_data = 1'b1;
    drain("timeout");
    send_frame(8'h45);
    exp_val_q.push_back(16'h0000);
    send_frame(8'h5A);
    drain("after_tmo");

    send_frame(8'h16); send_frame(8'h1E);
    send_bits({1'b1, 1'b0, 8'h36, 1'b0}, 4);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrst_value", {16'd0, value}, 0);
    check("midrst_valid", {31'd0, value_valid}, 0);
    check("midrst_count", {29'd0, digit_count}, 0);
    check("midrst_err", {31'd0, frame_error}, 0);
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    repeat (5) @(posedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    send_frame(8'h36); send_frame(8'hE0);
    exp_val_q.push_back(16'h0006);
    send_frame(8'h5A);
    drain("post_rst");
    check("post_rst_value", {16'd0, value}, 16'h0006);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
